// File: rtl/vpg_pkg.sv
// Shared types and defaults for the video-mode sequencer: FSM states, mode codes, timing defaults.
// No logic here; imported by the sequencer top.
`timescale 1ns/1ps
package vpg_pkg;

    typedef enum logic [3:0] {
        ST_INIT,
        ST_IDLE,
        ST_DEBOUNCE,
        ST_BLANK,
        ST_APPLY,
        ST_WAIT_UNLOCK,
        ST_WAIT_LOCK,
        ST_SETTLE,
        ST_FAIL
    } state_t;

    localparam logic [3:0] MODE_640X480   = 4'd0;
    localparam logic [3:0] MODE_720X480   = 4'd1;
    localparam logic [3:0] MODE_1024X768  = 4'd2;
    localparam logic [3:0] MODE_1280X1024 = 4'd3;
    localparam logic [3:0] MODE_1920X1080 = 4'd4;
    localparam logic [3:0] MODE_DEFAULT   = MODE_640X480;

    localparam int unsigned DEF_STABLE_CYCLES = 1000000;
    localparam int unsigned DEF_BLANK_CYCLES  = 16;
    localparam int unsigned DEF_UNLOCK_WAIT   = 1024;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 5000000;
    localparam int unsigned DEF_SETTLE_CYCLES = 256;
    localparam int unsigned DEF_MAX_RETRY     = 3;

endpackage

// File: rtl/vpg_sync.sv
// Two-flop synchronizer for asynchronous level inputs; 2-cycle latency, no flow control.
`timescale 1ns/1ps
module vpg_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/vpg_mode_sequencer.sv
// Debounces the requested video mode, blanks video, applies the mode and supervises the pixel-PLL relock.
// mode and the registered mode_change pulse update together on the edge leaving APPLY.
`timescale 1ns/1ps
module vpg_mode_sequencer
    import vpg_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned BLANK_CYCLES  = DEF_BLANK_CYCLES,
    parameter int unsigned UNLOCK_WAIT   = DEF_UNLOCK_WAIT,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned MAX_RETRY     = DEF_MAX_RETRY
) (
    input  logic       clk_50,
    input  logic       reset_n,
    input  logic [3:0] mode_req,
    input  logic       pll_locked,
    output logic [3:0] mode,
    output logic       mode_change,
    output logic       blank,
    output logic       busy,
    output logic       error
);

    localparam logic [31:0] L_INIT_LAST    = 32'd2;
    localparam logic [31:0] L_STABLE_LAST  = 32'(STABLE_CYCLES - 1);
    localparam logic [31:0] L_BLANK_LAST   = 32'(BLANK_CYCLES - 1);
    localparam logic [31:0] L_UNLOCK_LAST  = 32'(UNLOCK_WAIT - 1);
    localparam logic [31:0] L_TIMEOUT_LAST = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] L_SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
    localparam logic [7:0]  L_MAX_RETRY    = 8'(MAX_RETRY);

    state_t      r_state, w_state_nxt;
    logic [3:0]  r_cand, w_cand_nxt;
    logic [3:0]  r_mode, w_mode_nxt;
    logic [31:0] r_cnt, w_cnt_nxt;
    logic [7:0]  r_retry, w_retry_nxt;
    logic        r_error, w_error_nxt;
    logic        r_mode_change, w_pulse;
    logic        r_lock_q;
    logic [3:0]  w_req_s;
    logic        w_lock_s;
    logic        w_lock_fall;

    vpg_sync #(.WIDTH(4)) u_sync_req (
        .clk   (clk_50),
        .rst_n (reset_n),
        .i_d   (mode_req),
        .o_q   (w_req_s)
    );

    vpg_sync #(.WIDTH(1)) u_sync_lock (
        .clk   (clk_50),
        .rst_n (reset_n),
        .i_d   (pll_locked),
        .o_q   (w_lock_s)
    );

    // A lock that was already low before the pulse proves nothing; only a fresh drop ends WAIT_UNLOCK early.
    assign w_lock_fall = r_lock_q & ~w_lock_s;

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_INIT;
            r_cand        <= MODE_DEFAULT;
            r_mode        <= MODE_DEFAULT;
            r_cnt         <= '0;
            r_retry       <= '0;
            r_error       <= 1'b0;
            r_mode_change <= 1'b0;
            r_lock_q      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cand        <= w_cand_nxt;
            r_mode        <= w_mode_nxt;
            r_cnt         <= w_cnt_nxt;
            r_retry       <= w_retry_nxt;
            r_error       <= w_error_nxt;
            r_mode_change <= w_pulse;
            r_lock_q      <= w_lock_s;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_mode_nxt  = r_mode;
        w_retry_nxt = r_retry;
        w_error_nxt = r_error;
        w_pulse     = 1'b0;
        w_cnt_nxt   = (r_cnt == '1) ? r_cnt : r_cnt + 32'd1;

        case (r_state)
            ST_INIT: begin
                if (r_cnt == L_INIT_LAST) begin
                    w_cand_nxt  = w_req_s;
                    w_state_nxt = ST_BLANK;
                end
            end
            ST_IDLE, ST_FAIL: begin
                if (w_req_s != r_mode) begin
                    w_cand_nxt  = w_req_s;
                    w_state_nxt = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (w_req_s == r_mode) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_req_s != r_cand) begin
                    w_cand_nxt = w_req_s;
                    w_cnt_nxt  = '0;
                end else if (r_cnt == L_STABLE_LAST) begin
                    w_state_nxt = ST_BLANK;
                end
            end
            ST_BLANK: begin
                if (r_cnt == L_BLANK_LAST) w_state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                w_mode_nxt  = r_cand;
                w_pulse     = 1'b1;
                w_retry_nxt = '0;
                w_state_nxt = ST_WAIT_UNLOCK;
            end
            ST_WAIT_UNLOCK: begin
                if (w_lock_fall || r_cnt == L_UNLOCK_LAST) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s) begin
                    w_state_nxt = ST_SETTLE;
                end else if (r_cnt == L_TIMEOUT_LAST) begin
                    if (r_retry < L_MAX_RETRY) begin
                        w_retry_nxt = r_retry + 8'd1;
                        w_pulse     = 1'b1;
                        w_state_nxt = ST_WAIT_UNLOCK;
                    end else begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = ST_FAIL;
                    end
                end
            end
            ST_SETTLE: begin
                if (!w_lock_s) begin
                    w_state_nxt = ST_WAIT_LOCK;
                end else if (r_cnt == L_SETTLE_LAST) begin
                    w_error_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_INIT;
        endcase

        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    assign mode        = r_mode;
    assign mode_change = r_mode_change;
    assign error       = r_error;
    assign blank       = !(r_state == ST_IDLE || r_state == ST_DEBOUNCE);
    assign busy        = !(r_state == ST_IDLE || r_state == ST_FAIL);

endmodule

// File: tb/tb_vpg_mode_sequencer.sv
// Directed bench for vpg_mode_sequencer with short timing parameters.
`timescale 1ns/1ps
module tb_vpg_mode_sequencer;
    import vpg_pkg::*;

    logic       clk_50;
    logic       reset_n;
    logic [3:0] mode_req;
    logic       pll_locked;
    logic [3:0] mode;
    logic       mode_change;
    logic       blank;
    logic       busy;
    logic       error;

    int n_chk;
    int n_err;
    int cyc;
    int pulse_cnt;
    int pulse_at[16];

    vpg_mode_sequencer #(
        .STABLE_CYCLES (8),
        .BLANK_CYCLES  (2),
        .UNLOCK_WAIT   (4),
        .LOCK_TIMEOUT  (20),
        .SETTLE_CYCLES (4),
        .MAX_RETRY     (2)
    ) dut (
        .clk_50      (clk_50),
        .reset_n     (reset_n),
        .mode_req    (mode_req),
        .pll_locked  (pll_locked),
        .mode        (mode),
        .mode_change (mode_change),
        .blank       (blank),
        .busy        (busy),
        .error       (error)
    );

    initial clk_50 = 1'b0;
    always #5 clk_50 = ~clk_50;

    // mode_change seen here is the value held during the cycle just ended.
    always @(posedge clk_50) begin
        cyc <= cyc + 1;
        if (mode_change) begin
            if (pulse_cnt < 16) pulse_at[pulse_cnt] <= cyc;
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    logic blank_seen;

    initial begin
        n_chk = 0; n_err = 0; cyc = 0; pulse_cnt = 0;
        for (int i = 0; i < 16; i++) pulse_at[i] = 0;
        reset_n = 1'b0; mode_req = 4'd3; pll_locked = 1'b1;

        // Reset state
        tick(2);
        check_eq("rst_mode",   32'(mode), 32'd0);
        check_eq("rst_pulse",  32'(mode_change), 32'd0);
        check_eq("rst_blank",  32'(blank), 32'd1);
        check_eq("rst_busy",   32'(busy), 32'd1);
        check_eq("rst_error",  32'(error), 32'd0);
        check_eq("rst_state",  32'(dut.r_state), 32'(ST_INIT));

        // Power-up apply of mode 3 with a lock drop/return
        reset_n = 1'b1;
        tick(5);
        check_eq("pu_nopulse_yet", 32'(mode_change), 32'd0);
        tick(1);
        check_eq("pu_pulse", 32'(mode_change), 32'd1);
        check_eq("pu_mode",  32'(mode), 32'd3);
        pll_locked = 1'b0;
        tick(2);
        pll_locked = 1'b1;
        tick(6);
        check_eq("pu_settle_state", 32'(dut.r_state), 32'(ST_SETTLE));
        check_eq("pu_settle_blank", 32'(blank), 32'd1);
        tick(1);
        check_eq("pu_unblank",  32'(blank), 32'd0);
        check_eq("pu_idle",     32'(dut.r_state), 32'(ST_IDLE));
        check_eq("pu_busy",     32'(busy), 32'd0);
        check_eq("pu_error",    32'(error), 32'd0);
        check_eq("pu_mode_end", 32'(mode), 32'd3);
        check_eq("pu_pulses",   32'(pulse_cnt), 32'd1);

        // Bouncing request 1->2->1 then back to 3
        mode_req = 4'd1; tick(2);
        mode_req = 4'd2; tick(2);
        mode_req = 4'd1; tick(1);
        mode_req = 4'd3;
        blank_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            blank_seen = blank_seen | blank;
        end
        check_eq("bounce_blank",  32'(blank_seen), 32'd0);
        check_eq("bounce_pulses", 32'(pulse_cnt), 32'd1);
        check_eq("bounce_idle",   32'(dut.r_state), 32'(ST_IDLE));
        check_eq("bounce_mode",   32'(mode), 32'd3);

        // Mode 4, lock never drops: unlock wait times out
        mode_req = 4'd4;
        tick(13);
        check_eq("m4_nopulse_yet", 32'(mode_change), 32'd0);
        tick(1);
        check_eq("m4_pulse", 32'(mode_change), 32'd1);
        check_eq("m4_mode",  32'(mode), 32'd4);
        check_eq("m4_blank", 32'(blank), 32'd1);
        tick(3);
        check_eq("m4_still_unlock", 32'(dut.r_state), 32'(ST_WAIT_UNLOCK));
        tick(1);
        check_eq("m4_wait_lock", 32'(dut.r_state), 32'(ST_WAIT_LOCK));
        tick(5);
        check_eq("m4_idle",   32'(dut.r_state), 32'(ST_IDLE));
        check_eq("m4_blank0", 32'(blank), 32'd0);
        check_eq("m4_pulses", 32'(pulse_cnt), 32'd2);

        // Mode 2, one-cycle lock glitch during SETTLE
        mode_req = 4'd2;
        tick(14);
        check_eq("gl_pulse", 32'(mode_change), 32'd1);
        check_eq("gl_mode",  32'(mode), 32'd2);
        tick(5);
        check_eq("gl_settle1", 32'(dut.r_state), 32'(ST_SETTLE));
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        tick(2);
        check_eq("gl_relock_wait", 32'(dut.r_state), 32'(ST_WAIT_LOCK));
        check_eq("gl_nopulse",     32'(mode_change), 32'd0);
        tick(4);
        check_eq("gl_blank_hold", 32'(blank), 32'd1);
        check_eq("gl_settle2",    32'(dut.r_state), 32'(ST_SETTLE));
        tick(1);
        check_eq("gl_unblank", 32'(blank), 32'd0);
        check_eq("gl_idle",    32'(dut.r_state), 32'(ST_IDLE));
        check_eq("gl_pulses",  32'(pulse_cnt), 32'd3);

        // Mode 5 with the lock low for good: two retries then FAIL
        mode_req = 4'd5; pll_locked = 1'b0;
        tick(14);
        check_eq("to_pulse1", 32'(mode_change), 32'd1);
        check_eq("to_mode",   32'(mode), 32'd5);
        tick(71);
        check_eq("to_last_wait", 32'(dut.r_state), 32'(ST_WAIT_LOCK));
        check_eq("to_err_pre",   32'(error), 32'd0);
        check_eq("to_busy_pre",  32'(busy), 32'd1);
        tick(1);
        check_eq("to_fail_state", 32'(dut.r_state), 32'(ST_FAIL));
        check_eq("to_error",      32'(error), 32'd1);
        check_eq("to_blank",      32'(blank), 32'd1);
        check_eq("to_busy",       32'(busy), 32'd0);
        check_eq("to_pulses",     32'(pulse_cnt), 32'd6);
        check_eq("to_gap1",       32'(pulse_at[4] - pulse_at[3]), 32'd24);
        check_eq("to_gap2",       32'(pulse_at[5] - pulse_at[4]), 32'd24);
        tick(4);
        check_eq("to_no_more", 32'(pulse_cnt), 32'd6);
        check_eq("to_stay",    32'(dut.r_state), 32'(ST_FAIL));

        // Leave FAIL with mode 6, then reset while waiting for lock
        mode_req = 4'd6;
        tick(14);
        check_eq("rs_pulse", 32'(mode_change), 32'd1);
        check_eq("rs_mode",  32'(mode), 32'd6);
        tick(6);
        check_eq("rs_in_wait",  32'(dut.r_state), 32'(ST_WAIT_LOCK));
        check_eq("rs_err_kept", 32'(error), 32'd1);
        reset_n = 1'b0;
        tick(1);
        check_eq("rs_state", 32'(dut.r_state), 32'(ST_INIT));
        check_eq("rs_blank", 32'(blank), 32'd1);
        check_eq("rs_mode0", 32'(mode), 32'd0);
        check_eq("rs_error", 32'(error), 32'd0);
        check_eq("rs_busy",  32'(busy), 32'd1);
        pll_locked = 1'b1;
        tick(1);
        reset_n = 1'b1;
        tick(6);
        check_eq("rs_restart_pulse", 32'(mode_change), 32'd1);
        check_eq("rs_restart_mode",  32'(mode), 32'd6);
        tick(9);
        check_eq("rs_restart_idle",  32'(dut.r_state), 32'(ST_IDLE));
        check_eq("rs_restart_blank", 32'(blank), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
